// File: rtl/io_pio_pkg.sv
// Shared definitions for the io_pio output port: word map, pulse FSM states and STATUS bits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   PIO_* word indices, decoded from addr[7:2]
//   pulse_state_t: one-shot engine states
//   STAT_*_BIT: bit positions inside the STATUS read word
package io_pio_pkg;

    // Word indices as seen on addr[7:2]
    localparam logic [5:0] PIO_DATA      = 6'd0;
    localparam logic [5:0] PIO_SET       = 6'd1;
    localparam logic [5:0] PIO_CLR       = 6'd2;
    localparam logic [5:0] PIO_TGL       = 6'd3;
    localparam logic [5:0] PIO_PULSE_LEN = 6'd4;
    localparam logic [5:0] PIO_PULSE     = 6'd5;
    localparam logic [5:0] PIO_STATUS    = 6'd6;

    // One-shot engine states
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } pulse_state_t;

    // STATUS word bit positions
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_ERR_BIT  = 1;

endpackage : io_pio_pkg

// File: rtl/io_pio_pulse_timer.sv
// One-shot pulse timer: on start, stays busy for max(len,1) cycles, then flags expire.
// Latency: busy rises the cycle after start; expire is combinational in the last busy cycle.
// Backpressure: start is ignored while busy; the caller decides how to report that.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start      : begin a pulse (only honoured in IDLE)
//   len        : requested pulse length in cycles, 0 treated as 1
//   busy       : high while ACTIVE
//   expire     : high in the final ACTIVE cycle; the FSM returns to IDLE at its edge
module io_pio_pulse_timer
    import io_pio_pkg::*;
#(
    parameter int PULSE_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PULSE_W-1:0] len,
    output logic               busy,
    output logic               expire
);

    pulse_state_t       state_q, state_d;
    logic [PULSE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        expire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACTIVE;
                    // cnt counts the remaining cycles after the first one,
                    // so a zero length collapses to a single-cycle pulse.
                    if (len == '0) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = len - PULSE_W'(1);
                    end
                end
            end
            ST_ACTIVE: begin
                if (cnt_q == '0) begin
                    expire  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - PULSE_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == ST_ACTIVE);

endmodule : io_pio_pulse_timer

// File: rtl/io_pio_output_pulse.sv
// Memory-mapped parallel output port with atomic SET/CLR/TGL and a hardware one-shot inverter.
// Latency: writes take effect on pio and in readback one cycle after the write edge; reads are combinational.
// Backpressure: none; every access completes in its cycle, a PULSE write while busy is dropped and sets err.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   addr       : byte address, addr[7:2] selects the word
//   datain, we : write data and strobe
//   dataout    : read data for addr
//   pio        : registered output pins, base ^ mask
module io_pio_output_pulse
    import io_pio_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int PULSE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       addr,
    input  logic [31:0]      datain,
    input  logic             we,
    output logic [31:0]      dataout,
    output logic [WIDTH-1:0] pio
);

    logic [5:0]         word;
    logic [WIDTH-1:0]   wdat;

    logic [WIDTH-1:0]   base_q, base_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [PULSE_W-1:0] len_q, len_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   pio_q, pio_d;

    logic               pulse_wr;
    logic               start;
    logic               busy;
    logic               expire;
    logic [31:0]        status_word;

    // Byte lanes are not decoded, and datain bits above WIDTH carry no meaning.
    logic               unused_bits;
    assign unused_bits = ^{addr[1:0], datain};

    assign word = addr[7:2];
    assign wdat = datain[WIDTH-1:0];

    io_pio_pulse_timer #(
        .PULSE_W (PULSE_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .len    (len_q),
        .busy   (busy),
        .expire (expire)
    );

    // Write decode and next-state for the register file
    always_comb begin
        base_d   = base_q;
        len_d    = len_q;
        err_d    = err_q;
        pulse_wr = 1'b0;
        if (we) begin
            case (word)
                PIO_DATA:      base_d   = wdat;
                PIO_SET:       base_d   = base_q | wdat;
                PIO_CLR:       base_d   = base_q & ~wdat;
                PIO_TGL:       base_d   = base_q ^ wdat;
                PIO_PULSE_LEN: len_d    = datain[PULSE_W-1:0];
                PIO_PULSE:     pulse_wr = 1'b1;
                PIO_STATUS:    err_d    = 1'b0;
                default:       ;
            endcase
        end

        // A zero mask is a no-op and is not an error; any PULSE write while
        // busy (including the expiry cycle) is rejected so software retries.
        start = pulse_wr && !busy && (wdat != '0);
        if (pulse_wr && busy) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        mask_d = mask_q;
        if (start) begin
            mask_d = wdat;
        end else if (expire) begin
            mask_d = '0;
        end
        // Built from next-state values so pio lines up with register readback.
        pio_d = base_d ^ mask_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= '0;
            mask_q <= '0;
            len_q  <= '0;
            err_q  <= 1'b0;
            pio_q  <= '0;
        end else begin
            base_q <= base_d;
            mask_q <= mask_d;
            len_q  <= len_d;
            err_q  <= err_d;
            pio_q  <= pio_d;
        end
    end

    assign pio = pio_q;

    always_comb begin
        status_word                = '0;
        status_word[STAT_BUSY_BIT] = busy;
        status_word[STAT_ERR_BIT]  = err_q;
    end

    // Read mux, combinational from registers
    always_comb begin
        dataout = '0;
        case (word)
            PIO_DATA:      dataout = 32'(base_q);
            PIO_SET,
            PIO_CLR,
            PIO_TGL:       dataout = 32'(pio_q);
            PIO_PULSE_LEN: dataout = 32'(len_q);
            PIO_PULSE:     dataout = 32'(mask_q);
            PIO_STATUS:    dataout = status_word;
            default:       dataout = '0;
        endcase
    end

endmodule : io_pio_output_pulse

// File: tb/tb_io_pio_output_pulse.sv
// Directed bench for io_pio_output_pulse: register ops, pulse timing, rejection, reset abort.
// Latency: checks sample 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_io_pio_output_pulse;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  addr;
    logic [31:0] datain;
    logic        we;
    logic [31:0] dataout;
    logic [31:0] pio;

    int n_cmp = 0;
    int n_err = 0;

    io_pio_output_pulse #(
        .WIDTH   (32),
        .PULSE_W (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .datain  (datain),
        .we      (we),
        .dataout (dataout),
        .pio     (pio)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Combinational read of one word; does not advance the clock.
    task automatic rd_chk(input string tag, input logic [5:0] w, input logic [31:0] exp);
        addr = {w, 2'b00};
        #1;
        check(tag, dataout, exp);
    endtask

    // One write on the next edge; returns 1 unit after that edge.
    task automatic wr(input logic [5:0] w, input logic [31:0] d);
        addr   = {w, 2'b00};
        datain = d;
        we     = 1'b1;
        tick();
        we     = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        addr   = '0;
        datain = '0;
        we     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state: every word reads 0 and pins are low
        check("rst_pio", pio, 32'h0);
        for (int w = 0; w < 8; w++) begin
            rd_chk($sformatf("rst_rd%0d", w), 6'(w), 32'h0);
            tick();
        end

        // Direct and atomic updates
        wr(6'd0, 32'h0000_00F0);
        check("data_pio", pio, 32'h0000_00F0);
        rd_chk("data_rd", 6'd0, 32'h0000_00F0);
        wr(6'd1, 32'h0000_000F);
        check("set_pio", pio, 32'h0000_00FF);
        wr(6'd2, 32'h0000_0030);
        check("clr_pio", pio, 32'h0000_00CF);
        wr(6'd3, 32'h0000_0101);
        check("tgl_pio", pio, 32'h0000_01CE);
        rd_chk("tgl_rd_pio", 6'd3, 32'h0000_01CE);
        rd_chk("tgl_rd_base", 6'd0, 32'h0000_01CE);

        // Five-cycle pulse on bits 1:0
        wr(6'd0, 32'h0);
        wr(6'd4, 32'd5);
        rd_chk("len5_rd", 6'd4, 32'd5);
        wr(6'd5, 32'h3);
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("p5_pio_c%0d", k), pio, 32'h3);
            rd_chk($sformatf("p5_busy_c%0d", k), 6'd6, 32'h1);
            tick();
        end
        check("p5_pio_end", pio, 32'h0);
        rd_chk("p5_busy_end", 6'd6, 32'h0);
        rd_chk("p5_mask_end", 6'd5, 32'h0);

        // Zero length gives a single-cycle pulse; zero mask does nothing
        wr(6'd4, 32'd0);
        wr(6'd5, 32'h80);
        check("p1_pio", pio, 32'h80);
        rd_chk("p1_busy", 6'd6, 32'h1);
        tick();
        check("p1_pio_end", pio, 32'h0);
        rd_chk("p1_busy_end", 6'd6, 32'h0);
        wr(6'd5, 32'h0);
        check("p0_pio", pio, 32'h0);
        rd_chk("p0_busy", 6'd6, 32'h0);

        // Ten-cycle pulse on bit 0 with interference (write edge = N)
        wr(6'd4, 32'd10);
        wr(6'd5, 32'h1);                        // now cycle N+1
        check("p10_pio_c1", pio, 32'h1);
        wr(6'd5, 32'h2);                        // rejected, now N+2
        check("rej_pio", pio, 32'h1);
        rd_chk("rej_status", 6'd6, 32'h3);
        rd_chk("rej_mask", 6'd5, 32'h1);
        wr(6'd1, 32'h1);                        // base=1, now N+3
        check("set_in_pulse_pio", pio, 32'h0);
        wr(6'd6, 32'h0);                        // clear err, now N+4
        rd_chk("err_clr_status", 6'd6, 32'h1);
        for (int k = 0; k < 6; k++) tick();     // now N+10, last busy cycle
        check("p10_pio_c10", pio, 32'h0);
        rd_chk("p10_busy_c10", 6'd6, 32'h1);
        tick();                                 // N+11
        check("p10_pio_end", pio, 32'h1);
        rd_chk("p10_status_end", 6'd6, 32'h0);

        // PULSE write on the expiry edge: rejected, err set, FSM idles
        wr(6'd0, 32'h0);
        wr(6'd4, 32'd2);
        wr(6'd5, 32'h4);                        // N+1
        tick();                                 // N+2, expiry cycle
        wr(6'd5, 32'h8);                        // N+3
        check("exp_pulse_pio", pio, 32'h0);
        rd_chk("exp_pulse_status", 6'd6, 32'h2);
        wr(6'd6, 32'h0);
        rd_chk("exp_pulse_clr", 6'd6, 32'h0);

        // Base write on the expiry edge: both apply
        wr(6'd4, 32'd1);
        wr(6'd5, 32'h4);                        // N+1, expiry cycle
        check("exp_base_pulse", pio, 32'h4);
        wr(6'd0, 32'h10);
        check("exp_base_pio", pio, 32'h10);
        rd_chk("exp_base_mask", 6'd5, 32'h0);
        rd_chk("exp_base_status", 6'd6, 32'h0);

        // Reset in cycle 3 of an eight-cycle pulse
        wr(6'd0, 32'h0);
        wr(6'd4, 32'd8);
        wr(6'd5, 32'h1);                        // N+1
        tick();
        tick();                                 // N+3
        check("rst_mid_pre", pio, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_pio", pio, 32'h0);
        rd_chk("rst_mid_status", 6'd6, 32'h0);
        rd_chk("rst_mid_len", 6'd4, 32'h0);
        rd_chk("rst_mid_mask", 6'd5, 32'h0);
        tick();
        check("rst_mid_after", pio, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_io_pio_output_pulse

// File: doc/io_pio_output_pulse.md
# io_pio_output_pulse

Memory-mapped parallel output port, successor to the plain PIO output block, attached to the CPU's I/O bus decode like the other `io_*` peripherals. It holds a WIDTH-bit output register that can be written directly or through atomic SET/CLEAR/TOGGLE words, so software needs no read-modify-write. A hardware one-shot engine inverts a selected bit mask for a programmable number of clock cycles and then restores it autonomously. All registers are readable.

## Interface
- `WIDTH`, 32, number of output bits, 1..32
- `PULSE_W`, 16, pulse-length counter width, 1..32
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `addr`  in  8  byte address; `addr[7:2]` selects the word, `addr[1:0]` is ignored
- `datain`  in  32  write data
- `we`  in  1  write strobe, one access per cycle it is high
- `dataout`  out  32  read data for `addr`, combinational from registers
- `pio`  out  WIDTH  registered output pins

One clock; reset is synchronous and active-high.

## Operation
- State: `base[WIDTH-1:0]`, `mask[WIDTH-1:0]`, `len[PULSE_W-1:0]`, `cnt[PULSE_W-1:0]`, `err`, FSM {IDLE, ACTIVE}.
- `pio` is a register: `pio <= base_next ^ mask_next`.
- Word map (`addr[7:2]`), writes use `datain[WIDTH-1:0]`:
  - 0 DATA: W `base <= datain`; R `base`
  - 1 SET: W `base <= base | datain`; R `pio`
  - 2 CLR: W `base <= base & ~datain`; R `pio`
  - 3 TGL: W `base <= base ^ datain`; R `pio`
  - 4 PULSE_LEN: W `len <= datain[PULSE_W-1:0]`; R `len`, zero-extended
  - 5 PULSE: W starts a pulse; R `mask`
  - 6 STATUS: R `{30'b0, err, busy}`; any W clears `err`
  - All other words: write ignored, read 0. Unused upper read bits are 0.
- PULSE write in IDLE with `datain != 0`: `mask <= datain`, `cnt <= max(len,1) - 1`, go to ACTIVE.
- PULSE write in IDLE with `datain == 0`: no effect.
- ACTIVE: if `cnt == 0`, then `mask <= 0` and go to IDLE; else `cnt` decrements.
- PULSE write in ACTIVE: rejected. `mask` and `cnt` are unchanged and `err <= 1`.
- A `len` write during ACTIVE affects only the next pulse.
- DATA/SET/CLR/TGL writes during ACTIVE modify `base` normally. Pulsed bits show the inverse of the new `base` until expiry, then the new `base` value.
- `busy` = (state == ACTIVE).

## Timing
- Reset: `base=0`, `mask=0`, `len=0`, `cnt=0`, `err=0`, state IDLE. Therefore `pio=0` and `busy=0`.
- Write at edge N: the new `pio` and register values are visible from cycle N+1 (1-cycle latency).
- A PULSE at edge N with effective length L = max(len,1):
  - masked bits are inverted on `pio` for exactly L cycles (N+1 .. N+L);
  - the bits are restored at edge N+L;
  - `busy` is 1 for the same L cycles.
- Expiry edge coinciding with a PULSE write: the write is rejected and `err` is set. The FSM returns to IDLE, so software must retry.
- Expiry coinciding with a base write: both apply; `pio = base_next`.
- `dataout` is valid in the same cycle as `addr`, with no wait states.
- Reset asserted mid-pulse: reset values apply on the next edge and the pulse is aborted.

## Structure
- Package `io_pio_pkg`:
  - word-index constants (`PIO_DATA=0` .. `PIO_STATUS=6`);
  - FSM state typedef;
  - STATUS bit positions.
- Sub-module `io_pio_pulse_timer`, parameter PULSE_W.
  - Ports: clk, reset, start, len, busy, expire.
  - Contains the FSM and `cnt`.
- Top level: register file, SET/CLR/TGL logic, `mask`, `err`, read mux.

## Test plan
- Reset, then read all words → 0; `pio=0`.
- DATA=0x0000_00F0, SET 0x0F, CLR 0x30, TGL 0x101 → `pio=0x0000_01CE`, each step visible one cycle after its write.
- `len=5`, base=0, PULSE 0x3 → `pio=0x3` for exactly 5 cycles, then 0; `busy` high for 5 cycles; `mask` reads 0 after expiry.
- `len=0`, PULSE 0x80 → 1-cycle pulse on bit 7. PULSE 0 → no change and `busy` stays 0.
- During a `len=10` pulse of bit 0:
  - PULSE 0x2 → rejected and `err=1`; bit 1 never toggles;
  - SET 0x1 → `pio[0]=0` until expiry, then 1;
  - a STATUS write clears `err`.
- Assert `reset` at cycle 3 of a `len=8` pulse → next cycle `pio=0`, `busy=0`, `len=0`.
